// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Grants alternate under contention, the granted operands are steered to the
// ALU, and the result is captured into a single response slot.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | response slot free, rsp_valid=0
// FULL  | response slot holds a result, rsp_valid=1, waits for rsp_ready
module alu_arbiter #(
    parameter int PRIO_RESET = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic        rsp_zero,
    output logic        rsp_id,
    output logic        rsp_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t state;
    slot_t state_nxt;
    logic  last_gnt;
    logic  slot_avail;
    logic  gnt0;
    logic  gnt1;
    logic  accept;
    logic  op_legal;

    // Slot state register; reset empties the slot immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Grant selection and slot next-state. Grants are masked while rst is
    // high so nothing is handed out during reset.
    always_comb begin
        state_nxt  = state;
        slot_avail = (state == EMPTY) || rsp_ready;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (!rst && slot_avail) begin
            if (req0_valid && (!req1_valid || last_gnt)) gnt0 = 1'b1;
            else if (req1_valid)                         gnt1 = 1'b1;
        end
        accept = gnt0 | gnt1;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (rsp_ready) state_nxt = accept ? FULL : EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        rsp_valid  = (state == FULL);
    end

    // Steer the granted requester onto the ALU; idle drives zeros.
    always_comb begin
        alu_a  = 32'h0;
        alu_b  = 32'h0;
        alu_op = 4'h0;
        if (gnt0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (gnt1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    // Legal op codes: and, or, add, sub, unsigned slt.
    always_comb begin
        case (alu_op)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7: op_legal = 1'b1;
            default:                      op_legal = 1'b0;
        endcase
    end

    // Last-grant register moves only on an accepted request, so the loser of
    // a contention wins the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_gnt <= (PRIO_RESET == 0) ? 1'b1 : 1'b0;
        else if (accept) last_gnt <= gnt1;
    end

    // Response capture. Illegal ops report a clean zero result regardless of
    // what the ALU produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_res  <= 32'h0;
            rsp_zero <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_res  <= op_legal ? alu_res : 32'h0;
            rsp_zero <= op_legal ? alu_zero : 1'b1;
            rsp_id   <= gnt1;
            rsp_err  <= ~op_legal;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_zero, rsp_id, rsp_err;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.PRIO_RESET(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    // Shared ALU; unknown ops produce a nonzero xor so the arbiter's
    // illegal-op zeroing is visible.
    always_comb begin
        case (alu_op)
            4'd0:    alu_res = alu_a & alu_b;
            4'd1:    alu_res = alu_a | alu_b;
            4'd2:    alu_res = alu_a + alu_b;
            4'd6:    alu_res = alu_a - alu_b;
            4'd7:    alu_res = {31'h0, (alu_a < alu_b)};
            default: alu_res = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_res == 32'h0);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drv1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        drv0(1'b1, 4'd2, 32'd1, 32'd2);
        drv1(1'b1, 4'd0, 32'hF0, 32'h3C);
        #12;
        // reset state, with both requesters valid
        chk("rst_valid", rsp_valid, 0);
        chk("rst_res", rsp_res, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_alu_a", alu_a, 0);
        step();
        chk("rst_hold_valid", rsp_valid, 0);

        // contention from reset: 0,1,0,1
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("cont_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("cont_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
            step();
            chk("cont_valid", rsp_valid, 1);
            chk("cont_id", rsp_id, (i % 2 == 0) ? 0 : 1);
            chk("cont_res", rsp_res, (i % 2 == 0) ? 32'd3 : 32'h30);
        end
        drv0(1'b0, 4'd0, 0, 0);
        drv1(1'b0, 4'd0, 0, 0);
        #1;
        chk("idle_alu_op", alu_op, 0);
        chk("idle_alu_b", alu_b, 0);
        step();
        chk("drain_empty", rsp_valid, 0);

        // single request, consumer stalled
        rsp_ready = 1'b0;
        drv0(1'b1, 4'd2, 32'd5, 32'd7);
        #1;
        chk("single_rdy0", req0_ready, 1);
        chk("single_alu_a", alu_a, 5);
        step();
        chk("single_valid", rsp_valid, 1);
        chk("single_res", rsp_res, 12);
        chk("single_zero", rsp_zero, 0);
        chk("single_id", rsp_id, 0);
        chk("single_err", rsp_err, 0);

        // backpressure for 3 cycles with both requesters waiting
        drv0(1'b1, 4'd1, 32'h0F, 32'hF0);
        drv1(1'b1, 4'd7, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy0", req0_ready, 0);
            chk("bp_rdy1", req1_ready, 0);
            step();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_res", rsp_res, 12);
            chk("bp_id", rsp_id, 0);
        end
        // release: drain and accept req1 (req0 won last) in one cycle
        rsp_ready = 1'b1;
        #1;
        chk("rel_rdy0", req0_ready, 0);
        chk("rel_rdy1", req1_ready, 1);
        step();
        chk("rel_valid", rsp_valid, 1);
        chk("rel_res_slt", rsp_res, 1);
        chk("rel_id", rsp_id, 1);
        // req0 now wins, or-op
        step();
        chk("rel2_id", rsp_id, 0);
        chk("rel2_res_or", rsp_res, 32'hFF);
        drv0(1'b0, 4'd0, 0, 0);

        // zero result then illegal op from req1
        drv1(1'b1, 4'd6, 32'd9, 32'd9);
        step();
        chk("zero_res", rsp_res, 0);
        chk("zero_zero", rsp_zero, 1);
        chk("zero_id", rsp_id, 1);
        chk("zero_err", rsp_err, 0);
        drv1(1'b1, 4'd3, 32'd5, 32'd6);
        step();
        chk("ill_valid", rsp_valid, 1);
        chk("ill_res", rsp_res, 0);
        chk("ill_err", rsp_err, 1);
        chk("ill_zero", rsp_zero, 1);
        drv1(1'b0, 4'd0, 0, 0);
        step();
        chk("ill_drain", rsp_valid, 0);

        // reset mid-operation while FULL
        rsp_ready = 1'b0;
        drv0(1'b1, 4'd2, 32'd1, 32'd1);
        step();
        drv0(1'b0, 4'd0, 0, 0);
        chk("pre_rst_valid", rsp_valid, 1);
        chk("pre_rst_res", rsp_res, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_res", rsp_res, 0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("post_rst_valid", rsp_valid, 0);
        step();
        chk("post_rst_valid2", rsp_valid, 0);
        // priority restored to requester 0 after reset
        drv0(1'b1, 4'd0, 32'hFF00, 32'h0FF0);
        drv1(1'b1, 4'd2, 32'd10, 32'd20);
        #1;
        chk("post_rst_rdy0", req0_ready, 1);
        chk("post_rst_rdy1", req1_ready, 0);
        step();
        chk("post_rst_id", rsp_id, 0);
        chk("post_rst_res", rsp_res, 32'h0F00);
        step();
        chk("post_rst_id2", rsp_id, 1);
        chk("post_rst_res2", rsp_res, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_RESET, default 0, requester granted first after reset when both request (0 or 1).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands of requester N.
REQ-007 reqN_op  input  4  ALU op code of requester N (0 and, 1 or, 2 add, 6 sub, 7 slt unsigned).
REQ-008 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-009 alu_op  output  4  op code driven to the shared ALU.
REQ-010 alu_res  input  32  combinational ALU result.
REQ-011 alu_zero  input  1  combinational ALU zero flag.
REQ-012 rsp_valid  output  1  response register holds a result.
REQ-013 rsp_ready  input  1  consumer takes the response this cycle.
REQ-014 rsp_res  output  32  registered result.
REQ-015 rsp_zero  output  1  registered zero flag.
REQ-016 rsp_id  output  1  requester that issued the response.
REQ-017 rsp_err  output  1  op code was not one of 0,1,2,6,7.

Function
REQ-018 Response slot SHALL be a two-state machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-019 Slot is available when EMPTY, or when FULL and rsp_ready=1 in the same cycle.
REQ-020 At most one request SHALL be granted per cycle, and only when the slot is available.
REQ-021 With one requester valid, that requester SHALL be granted; with both valid, the requester not granted most recently SHALL be granted.
REQ-022 The last-grant register SHALL update only on an accepted request.
REQ-023 reqN_ready SHALL be 1 exactly when requester N is granted, combinationally from valids and slot state. It SHALL NOT depend on reqN_a/b/op.
REQ-024 Requesters SHALL NOT make reqN_valid depend on reqN_ready.
REQ-025 alu_a/alu_b/alu_op SHALL carry the granted requester's operands; with no grant they SHALL be driven to 0.
REQ-026 On acceptance, rsp_res and rsp_zero SHALL capture alu_res and alu_zero, and rsp_id SHALL capture the granted index. The slot becomes FULL at the next edge, giving 1-cycle latency.
REQ-027 For an illegal op, rsp_err=1 and rsp_res SHALL be 32'h0, with rsp_zero=1 regardless of alu_res.
REQ-028 While FULL with rsp_ready=0, all rsp_* outputs SHALL hold stable and both reqN_ready SHALL be 0.
REQ-029 FULL with rsp_ready=1 and a grant SHALL reload the slot (stays FULL); without a grant, the slot goes EMPTY.
REQ-030 Sustained throughput SHALL be one operation per cycle when rsp_ready is held 1.
REQ-031 No operation SHALL be lost or duplicated; each accepted request SHALL produce exactly one response, in acceptance order.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, force rsp_valid=0, rsp_res=0, rsp_zero=0, rsp_id=0 and rsp_err=0.
REQ-033 During rst=1, last-grant SHALL be set to 1-PRIO_RESET, so PRIO_RESET wins the first contention.
REQ-034 During rst=1, reqN_ready SHALL be 0.
REQ-035 A result held when reset asserts SHALL be discarded, and no response SHALL appear for it afterwards.
REQ-036 After rst deasserts, the first acceptance SHALL occur at the first clk edge with a valid request.

Verification
REQ-037 Bench SHALL connect the team's ALU to alu_* ports and cover these scenarios:
REQ-038 Single request: req0 op=2, a=5, b=7 -> next cycle rsp_valid=1, rsp_res=12, rsp_zero=0, rsp_id=0, rsp_err=0.
REQ-039 Contention: both valid continuously, rsp_ready=1, PRIO_RESET=0 -> rsp_id sequence 0,1,0,1 with one response per cycle.
REQ-040 Backpressure: slot FULL with rsp_ready=0 for 3 cycles -> both readys 0 and rsp_* unchanged. Raising rsp_ready -> drain plus new accept in the same cycle.
REQ-041 Zero and illegal op: req1 op=6, a=b=9 -> rsp_res=0, rsp_zero=1, rsp_id=1. Then op=3 -> rsp_res=0, rsp_err=1.
REQ-042 Reset mid-operation: assert rst between edges while FULL -> rsp_valid falls before the next edge, and no stale response appears after release.
